// File: rtl/uart_rx_param.sv
// uart_rx_param: parameterised 16x-oversampled UART receiver.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at ticks 7/8/9.
module uart_rx_param #(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxEn,
    input  logic                 rxIn,
    output logic                 rxBusy,
    output logic                 rxDone,
    output logic                 rxErr,
    output logic                 rxParityErr,
    output logic [DATA_BITS-1:0] rxOut
);
    localparam int DIV = (CLOCK_RATE + BAUD_RATE * 8) / (BAUD_RATE * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] SMP_T = 4'd8;
`else
    localparam logic [3:0] SMP_T = 4'd7;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic [3:0]           tcnt_q, tcnt_d;
    logic [3:0]           bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] out_q, out_d;
    logic                 ferr_p_q, ferr_p_d;
    logic                 perr_p_q, perr_p_d;
    logic                 err_q, err_d;
    logic                 perr_q, perr_d;
    logic                 done_q, done_d;
    logic                 rx_prev_q;

    logic run, busy, tick, bit_end, smp_now, smp_bit, start_edge, par_x;

    assign run        = (state_q != S_IDLE);
    assign busy       = (state_q == S_START) || (state_q == S_DATA) ||
                        (state_q == S_PARITY) || (state_q == S_STOP);
    assign tick       = run && (div_q == DW'(DIV - 1));
    assign bit_end    = tick && (tcnt_q == 4'd15);
    assign smp_now    = tick && (tcnt_q == SMP_T);
    assign start_edge = rxEn && rx_prev_q && !rxIn;
    assign par_x      = ^{shift_q, smp_bit};

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] maj_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maj_q <= '0;
        end else if (tick && tcnt_q == 4'd6) begin
            maj_q[0] <= rxIn;
        end else if (tick && tcnt_q == 4'd7) begin
            maj_q[1] <= rxIn;
        end
    end

    assign smp_bit = (maj_q[0] & maj_q[1]) | (maj_q[0] & rxIn) |
                     (maj_q[1] & rxIn);
`else
    assign smp_bit = rxIn;
`endif

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        tcnt_d   = tcnt_q;
        bcnt_d   = bcnt_q;
        shift_d  = shift_q;
        ferr_p_d = ferr_p_q;
        perr_p_d = perr_p_q;
        out_d    = out_q;
        err_d    = err_q;
        perr_d   = perr_q;
        done_d   = 1'b0;
        if (run) begin
            div_d = tick ? '0 : div_q + DW'(1);
            if (tick) tcnt_d = tcnt_q + 4'd1;
        end
        // Losing the enable mid-frame discards the frame, leaving outputs as they were
        if (busy && !rxEn) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    div_d  = '0;
                    tcnt_d = '0;
                    bcnt_d = '0;
                    if (start_edge) state_d = S_START;
                end
                S_START: begin
                    if (smp_now) begin
                        if (smp_bit) begin
                            state_d = S_IDLE;
                        end else begin
                            err_d    = 1'b0;
                            perr_d   = 1'b0;
                            ferr_p_d = 1'b0;
                            perr_p_d = 1'b0;
                        end
                    end else if (bit_end) begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (smp_now) shift_d = {smp_bit, shift_q[DATA_BITS-1:1]};
                    if (bit_end) begin
                        bcnt_d = bcnt_q + 4'd1;
                        if (bcnt_q == LAST_DATA) begin
                            bcnt_d  = '0;
                            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (smp_now) perr_p_d = (PARITY == 1) ? ~par_x : par_x;
                    if (bit_end) state_d = S_STOP;
                end
                S_STOP: begin
                    if (smp_now) begin
                        if (!smp_bit) ferr_p_d = 1'b1;
                        if (bcnt_q == LAST_STOP) begin
                            done_d  = 1'b1;
                            out_d   = shift_q;
                            err_d   = ferr_p_q | ~smp_bit;
                            perr_d  = perr_p_q;
                            tcnt_d  = '0;
                            state_d = smp_bit ? S_IDLE : S_WAIT_HIGH;
                        end
                    end else if (bit_end) begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end
                S_WAIT_HIGH: begin
                    // tcnt counts consecutive high ticks of a line leaving break
                    if (!rxIn) tcnt_d = '0;
                    else if (bit_end) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            out_q     <= '0;
            ferr_p_q  <= 1'b0;
            perr_p_q  <= 1'b0;
            err_q     <= 1'b0;
            perr_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            out_q     <= out_d;
            ferr_p_q  <= ferr_p_d;
            perr_p_q  <= perr_p_d;
            err_q     <= err_d;
            perr_q    <= perr_d;
            done_q    <= done_d;
            rx_prev_q <= rxIn;
        end
    end

    assign rxBusy      = busy;
    assign rxDone      = done_q;
    assign rxErr       = err_q;
    assign rxParityErr = perr_q;
    assign rxOut       = out_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for uart_rx_param over three builds
// (defaults; 7-bit even parity 2 stop; 9-bit odd parity, rounded divider).
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int BP0 = 1248; // 12 MHz / 9600: 78 clk per tick
    localparam int BP1 = 64;   // 1 MHz / 15625: 4 clk per tick
    localparam int BP2 = 80;   // 1.15 MHz / 15625: 4.6 rounds to 5 clk per tick

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic [2:0] rstn_v;
    logic [2:0] rx_en;
    logic [2:0] rx_in;
    logic [2:0] busy, done, err, perr;
    logic [7:0] out0;
    logic [6:0] out1;
    logic [8:0] out2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic [8:0] last_out [3];
    logic       last_ferr[3];
    logic       last_perr[3];
    logic [2:0] done_prev;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_param u0 (
        .clk(clk), .rst_n(rstn_v[0]), .rxEn(rx_en[0]), .rxIn(rx_in[0]),
        .rxBusy(busy[0]), .rxDone(done[0]), .rxErr(err[0]),
        .rxParityErr(perr[0]), .rxOut(out0)
    );
    uart_rx_param #(
        .CLOCK_RATE(1000000), .BAUD_RATE(15625), .DATA_BITS(7),
        .PARITY(2), .STOP_BITS(2)
    ) u1 (
        .clk(clk), .rst_n(rstn_v[1]), .rxEn(rx_en[1]), .rxIn(rx_in[1]),
        .rxBusy(busy[1]), .rxDone(done[1]), .rxErr(err[1]),
        .rxParityErr(perr[1]), .rxOut(out1)
    );
    uart_rx_param #(
        .CLOCK_RATE(1150000), .BAUD_RATE(15625), .DATA_BITS(9),
        .PARITY(1), .STOP_BITS(1)
    ) u2 (
        .clk(clk), .rst_n(rstn_v[2]), .rxEn(rx_en[2]), .rxIn(rx_in[2]),
        .rxBusy(busy[2]), .rxDone(done[2]), .rxErr(err[2]),
        .rxParityErr(perr[2]), .rxOut(out2)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] get_out(input int id);
        case (id)
            0: return {1'b0, out0};
            1: return {2'b0, out1};
            default: return out2;
        endcase
    endfunction

    function automatic logic [8:0] mask(input int nb);
        int m;
        m = (1 << nb) - 1;
        return 9'(m);
    endfunction

    function automatic int qsize(input int id);
        case (id)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push(input int id, input exp_t e);
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
        last_out[id]  = e.data;
        last_ferr[id] = e.ferr;
        last_perr[id] = e.perr;
    endtask

    function automatic exp_t qpop(input int id);
        case (id)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Expected outcome of one frame from the line-level description
    function automatic exp_t model(input int nb, input logic [8:0] d,
                                   input int pm, input logic pb,
                                   input logic [1:0] st, input int ns);
        exp_t e;
        int ones;
        e.data = d & mask(nb);
        ones = $countones(e.data) + ((pb === 1'b1) ? 1 : 0);
        e.perr = (pm == 1) ? (ones % 2 == 0) : (pm == 2) ? (ones % 2 == 1) : 1'b0;
        e.ferr = (st[0] == 1'b0) || (ns == 2 && st[1] == 1'b0);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (done[i]) begin
                chk($sformatf("busy_low_with_done%0d", i), busy[i], 0);
                chk($sformatf("done_one_clk%0d", i), done_prev[i], 0);
                if (qsize(i) == 0) begin
                    chk($sformatf("unexpected_done%0d", i), 1, 0);
                end else begin
                    e = qpop(i);
                    chk($sformatf("rxOut%0d", i), get_out(i), e.data);
                    chk($sformatf("rxParityErr%0d", i), perr[i], e.perr);
                    chk($sformatf("rxErr%0d", i), err[i], e.ferr);
                end
            end
        end
        done_prev <= done;
    end

    task automatic drive(input int id, input logic v, input int n);
        rx_in[id] = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int id, input int bp, input int nb,
                        input logic [8:0] d, input int pm, input logic pb,
                        input logic [1:0] st, input int ns, input int gbit);
        drive(id, 1'b0, bp);
        for (int i = 0; i < nb; i++) begin
            if (i == gbit) begin
                drive(id, d[i], bp / 2 - bp / 32);
                drive(id, ~d[i], bp / 16);
                drive(id, d[i], bp / 2 - bp / 32);
            end else begin
                drive(id, d[i], bp);
            end
            if (i == 0) begin
                chk($sformatf("busy_in_frame%0d", id), busy[id], 1);
                chk($sformatf("err_cleared%0d", id), err[id], 0);
                chk($sformatf("perr_cleared%0d", id), perr[id], 0);
            end
        end
        if (pm != 0) drive(id, pb, bp);
        for (int i = 0; i < ns; i++) drive(id, st[i], bp);
    endtask

    task automatic hold_checks(input int id);
        chk($sformatf("hold_out%0d", id), get_out(id), last_out[id]);
        chk($sformatf("hold_err%0d", id), err[id], last_ferr[id]);
        chk($sformatf("hold_perr%0d", id), perr[id], last_perr[id]);
    endtask

    task automatic rand_frames(input int id, input int bp, input int nb,
                               input int pm, input int ns, input int n);
        exp_t e;
        logic [8:0] d;
        logic pb;
        logic [1:0] st;
        int ones;
        for (int k = 0; k < n; k++) begin
            hold_checks(id);
            d = 9'($urandom) & mask(nb);
            ones = $countones(d);
            pb = (pm == 1) ? ~ones[0] : ones[0];
            if ($urandom_range(3) == 0) pb = ~pb;
            st = 2'b11;
            if ($urandom_range(3) == 0) st = 2'($urandom);
            e = model(nb, d, pm, pb, st, ns);
            push(id, e);
            send(id, bp, nb, d, pm, pb, st, ns, -1);
            drive(id, 1'b1, 2 * bp);
        end
    endtask

    task automatic run_dut0();
        exp_t e;
        e = model(8, 9'h35, 0, 1'b0, 2'b11, 1);
        push(0, e);
        send(0, BP0, 8, 9'h35, 0, 1'b0, 2'b11, 1, -1);
        drive(0, 1'b1, BP0);
        hold_checks(0);
        // Short low pulse: accepted as a possible start, rejected at mid-bit
        drive(0, 1'b0, 5);
        drive(0, 1'b1, 20);
        chk("glitch_busy_high", busy[0], 1);
        drive(0, 1'b1, BP0 / 2);
        chk("glitch_busy_low", busy[0], 0);
        chk("glitch_out_kept", out0, 8'h35);
        drive(0, 1'b1, BP0);
        // One-tick glitch centred on the mid-bit sample of data bit 2
        e = model(8, 9'h35, 0, 1'b0, 2'b11, 1);
`ifndef UART_RX_MAJORITY_EN
        e.data[2] = ~e.data[2];
`endif
        push(0, e);
        send(0, BP0, 8, 9'h35, 0, 1'b0, 2'b11, 1, 2);
        drive(0, 1'b1, BP0);
        hold_checks(0);
        // Reset in the middle of an all-zero frame
        drive(0, 1'b0, 3 * BP0);
        chk("pre_reset_busy", busy[0], 1);
        rstn_v[0] = 1'b0;
        #1;
        chk("rst_busy", busy[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_err", err[0], 0);
        chk("rst_perr", perr[0], 0);
        chk("rst_out", out0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rstn_v[0] = 1'b1;
        drive(0, 1'b0, BP0);
        chk("no_start_without_edge", busy[0], 0);
        drive(0, 1'b1, BP0);
    endtask

    task automatic run_dut1();
        exp_t e;
        logic [8:0] d;
        e = model(7, 9'h35, 2, 1'b1, 2'b11, 2);
        push(1, e);
        send(1, BP1, 7, 9'h35, 2, 1'b1, 2'b11, 2, -1);
        drive(1, 1'b1, 2 * BP1);
        e = model(7, 9'h35, 2, 1'b0, 2'b11, 2);
        push(1, e);
        send(1, BP1, 7, 9'h35, 2, 1'b0, 2'b11, 2, -1);
        drive(1, 1'b1, 2 * BP1);
        hold_checks(1);
        // Second stop low, then break: line stays low
        e = model(7, 9'h12, 2, 1'b0, 2'b01, 2);
        push(1, e);
        send(1, BP1, 7, 9'h12, 2, 1'b0, 2'b01, 2, -1);
        drive(1, 1'b0, 3 * BP1);
        drive(1, 1'b1, BP1 / 2);
        drive(1, 1'b0, BP1 / 4);
        chk("break_no_start", busy[1], 0);
        drive(1, 1'b0, BP1 - BP1 / 4);
        chk("break_still_idle", busy[1], 0);
        drive(1, 1'b1, 2 * BP1);
        chk("break_err_hold", err[1], 1);
        rand_frames(1, BP1, 7, 2, 2, 3);
        // Enable dropped once data bit 3 has gone by
        d = 9'h55;
        drive(1, 1'b0, BP1);
        for (int i = 0; i < 4; i++) drive(1, d[i], BP1);
        chk("abort_busy_before", busy[1], 1);
        rx_en[1] = 1'b0;
        drive(1, d[4], 1);
        chk("abort_busy_low", busy[1], 0);
        hold_checks(1);
        drive(1, d[4], BP1 - 1);
        drive(1, d[5], BP1);
        drive(1, d[6], BP1);
        drive(1, 1'b0, BP1);
        drive(1, 1'b1, 3 * BP1);
        rx_en[1] = 1'b1;
        drive(1, 1'b1, BP1);
        hold_checks(1);
        rand_frames(1, BP1, 7, 2, 2, 20);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_v    = 3'b000;
        rx_en     = 3'b000;
        rx_in     = 3'b111;
        done_prev = 3'b000;
        for (int i = 0; i < 3; i++) begin
            last_out[i]  = '0;
            last_ferr[i] = 1'b0;
            last_perr[i] = 1'b0;
        end
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_busy%0d", i), busy[i], 0);
            chk($sformatf("reset_done%0d", i), done[i], 0);
            chk($sformatf("reset_err%0d", i), err[i], 0);
            chk($sformatf("reset_perr%0d", i), perr[i], 0);
            chk($sformatf("reset_out%0d", i), get_out(i), 0);
        end
        rstn_v = 3'b111;
        rx_en  = 3'b111;
        repeat (4) @(posedge clk);
        #1;
        fork
            run_dut0();
            run_dut1();
            rand_frames(2, BP2, 9, 1, 1, 25);
        join
        repeat (10) @(posedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("all_frames_seen%0d", i), qsize(i), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL take parameter CLOCK_RATE, default 12000000, meaning the clk frequency in Hz.
REQ-002 The block SHALL take parameter BAUD_RATE, default 9600, meaning the line bit rate.
REQ-003 The block SHALL take parameter DATA_BITS, default 8, legal range 5..9, meaning payload bits per frame.
REQ-004 The block SHALL take parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 The block SHALL take parameter STOP_BITS, default 1, legal range 1..2, meaning stop bits checked per frame.
REQ-006 The block SHALL have port clk, input, 1 bit, the single system clock; all logic SHALL be on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-008 The block SHALL have port rxEn, input, 1 bit, the receiver enable.
REQ-009 The block SHALL have port rxIn, input, 1 bit, the serial line, idle high.
REQ-010 The block SHALL have port rxBusy, output, 1 bit, high while a frame is being received.
REQ-011 The block SHALL have port rxDone, output, 1 bit, a one-clk pulse per completed frame.
REQ-012 The block SHALL have port rxErr, output, 1 bit, the framing error flag.
REQ-013 The block SHALL have port rxParityErr, output, 1 bit, the parity error flag.
REQ-014 The block SHALL have port rxOut, output, DATA_BITS wide, the last received payload.

Function
REQ-015 The block SHALL produce a 16x oversample tick every DIV = round(CLOCK_RATE/(BAUD_RATE*16)) clk cycles (78 at defaults), free-running only while rxBusy is high, and reloaded on frame start.
REQ-016 The block SHALL implement the states IDLE, START, DATA, PARITY, STOP, and WAIT_HIGH.
REQ-017 In IDLE with rxEn high, a 1-to-0 transition on rxIn SHALL enter START and raise rxBusy on the next clk.
REQ-018 In START, rxIn SHALL be sampled at tick 8; a high sample SHALL return to IDLE (glitch reject) with rxBusy low and no rxDone.
REQ-019 DATA SHALL sample DATA_BITS bits LSB first, one every 16 ticks at mid-bit, then go to PARITY if PARITY is nonzero, else to STOP.
REQ-020 PARITY SHALL sample one bit; rxParityErr SHALL be set if the XOR of the data and parity bits is 0 when PARITY is odd, or 1 when PARITY is even.
REQ-021 STOP SHALL sample STOP_BITS bits; any low sample SHALL set rxErr.
REQ-022 On the clk after the final stop sample: rxOut SHALL load the payload, rxDone SHALL pulse high for exactly one clk, and rxBusy SHALL fall in the same cycle.
REQ-023 rxDone SHALL pulse even when rxErr or rxParityErr is set.
REQ-024 rxErr and rxParityErr SHALL hold until the next accepted start (REQ-018 passed), then clear.
REQ-025 On a framing error with rxIn low, the block SHALL enter WAIT_HIGH and SHALL NOT detect a new start until rxIn has been high for 16 ticks (break handling).
REQ-026 rxEn deasserted mid-frame SHALL abort to IDLE on the next clk: rxBusy low, no rxDone, rxOut and flags unchanged.
REQ-027 rxOut SHALL hold its value between rxDone pulses.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, counters to 0, rxBusy/rxDone/rxErr/rxParityErr to 0, and rxOut to all zeros, including mid-frame.
REQ-029 After rst_n rises, a start SHALL be detected only on a fresh 1-to-0 edge of rxIn.

Configuration
REQ-030 With macro UART_RX_MAJORITY_EN defined, each bit SHALL be the 2-of-3 majority of samples at ticks 7, 8, and 9; without it, each bit SHALL be the single sample at tick 8.

Verification
REQ-031 Defaults, frame 0x35, bit period 1248 clk -> rxDone once, rxOut=0x35, rxErr=0, rxParityErr=0.
REQ-032 rxIn pulsed low for 5 clk while idle -> rxBusy falls after tick 8, no rxDone, rxOut unchanged.
REQ-033 PARITY=2, 0x35 sent with parity bit 1 -> rxDone, rxOut=0x35, rxParityErr=1; with parity bit 0 -> rxParityErr=0.
REQ-034 STOP_BITS=2, second stop bit held low then line held low -> rxErr=1, rxDone pulse, no new start until 16 high ticks.
REQ-035 rxEn dropped after data bit 3 -> rxBusy=0 next clk, no rxDone; an asserted rst_n mid-frame -> all outputs 0 immediately.
REQ-036 UART_RX_MAJORITY_EN defined, a 1-tick glitch at tick 8 of bit 2 -> rxOut still 0x35; without the macro -> rxOut=0x31.
